// File: rtl/stream_pattern_checker.sv
// Sink-side checker for the replicated-byte incrementing test stream.
// Tracks burst length and sequence, and keeps per-burst results, counters and a first-error snapshot.
module stream_pattern_checker #(
  parameter int BURST_LEN = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             Clear,
  input  logic [31:0]      DataIn,
  input  logic             DataInValid,
  output logic             BurstDone,
  output logic             BurstOk,
  output logic             ErrSticky,
  output logic [CNT_W-1:0] BurstCount,
  output logic [CNT_W-1:0] ErrCount,
  output logic [31:0]      FirstErrExp,
  output logic [31:0]      FirstErrGot,
  output logic [15:0]      FirstErrIdx
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0]      LEN16   = 16'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_reg, state_next;
  logic [15:0]        word_cnt_reg, word_cnt_next;
  logic [7:0]         exp_reg, exp_next;
  logic               burst_bad_reg, burst_bad_next;
  logic               done_reg, ok_reg, sticky_reg;
  logic [CNT_W-1:0]   burst_cnt_reg, err_cnt_reg;
  logic [31:0]        cap_exp_reg, cap_got_reg;
  logic [15:0]        cap_idx_reg;

  logic               word_err, len_err, burst_end, any_err;
  logic [31:0]        cap_exp, cap_got;
  logic [15:0]        cap_idx;

  always_ff @(posedge clk) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (DataInValid)  state_next = RUN;
      RUN:     if (!DataInValid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    word_err       = 1'b0;
    len_err        = 1'b0;
    burst_end      = 1'b0;
    word_cnt_next  = word_cnt_reg;
    exp_next       = exp_reg;
    burst_bad_next = burst_bad_reg;
    cap_exp        = 32'd0;
    cap_got        = DataIn;
    cap_idx        = word_cnt_reg;
    case (state_reg)
      IDLE: if (DataInValid) begin
        // No start value is assumed: the first word only has to be self-consistent.
        word_err       = (DataIn != {4{DataIn[7:0]}});
        cap_exp        = {4{DataIn[7:0]}};
        cap_idx        = 16'd0;
        word_cnt_next  = 16'd1;
        exp_next       = DataIn[7:0] + 8'd1;
        burst_bad_next = word_err;
      end
      RUN: if (DataInValid) begin
        word_err       = (DataIn != {4{exp_reg}});
        cap_exp        = {4{exp_reg}};
        // Resync on the received byte so one skipped value costs one error.
        exp_next       = DataIn[7:0] + 8'd1;
        word_cnt_next  = (word_cnt_reg == 16'hFFFF) ? word_cnt_reg : word_cnt_reg + 16'd1;
        burst_bad_next = burst_bad_reg | word_err;
      end else begin
        burst_end = 1'b1;
        len_err   = (word_cnt_reg != LEN16);
        cap_exp   = 32'(BURST_LEN);
        cap_got   = {16'd0, word_cnt_reg};
        cap_idx   = 16'hFFFF;
      end
      default: ;
    endcase
    any_err = word_err | len_err;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      word_cnt_reg  <= '0;
      exp_reg       <= '0;
      burst_bad_reg <= 1'b0;
      done_reg      <= 1'b0;
      ok_reg        <= 1'b0;
      sticky_reg    <= 1'b0;
      burst_cnt_reg <= '0;
      err_cnt_reg   <= '0;
      cap_exp_reg   <= '0;
      cap_got_reg   <= '0;
      cap_idx_reg   <= '0;
    end else begin
      word_cnt_reg  <= word_cnt_next;
      exp_reg       <= exp_next;
      burst_bad_reg <= burst_bad_next;
      done_reg      <= burst_end;
      if (burst_end) ok_reg <= !(burst_bad_reg | len_err);
      // Clear wins over any same-cycle bookkeeping; per-burst status is kept.
      if (Clear) begin
        sticky_reg    <= 1'b0;
        burst_cnt_reg <= '0;
        err_cnt_reg   <= '0;
        cap_exp_reg   <= '0;
        cap_got_reg   <= '0;
        cap_idx_reg   <= '0;
      end else begin
        if (burst_end && burst_cnt_reg != CNT_MAX) burst_cnt_reg <= burst_cnt_reg + 1'b1;
        if (any_err && err_cnt_reg != CNT_MAX)     err_cnt_reg   <= err_cnt_reg + 1'b1;
        if (any_err) begin
          sticky_reg <= 1'b1;
          if (!sticky_reg) begin
            cap_exp_reg <= cap_exp;
            cap_got_reg <= cap_got;
            cap_idx_reg <= cap_idx;
          end
        end
      end
    end
  end

  assign BurstDone   = done_reg;
  assign BurstOk     = ok_reg;
  assign ErrSticky   = sticky_reg;
  assign BurstCount  = burst_cnt_reg;
  assign ErrCount    = err_cnt_reg;
  assign FirstErrExp = cap_exp_reg;
  assign FirstErrGot = cap_got_reg;
  assign FirstErrIdx = cap_idx_reg;

endmodule

// File: tb/tb_stream_pattern_checker.sv
// Directed bench for stream_pattern_checker: full-width instance plus a 4-bit-counter instance for saturation.
module tb_stream_pattern_checker;

  logic        clk = 1'b0;
  logic        rstn, Clear, DataInValid;
  logic [31:0] DataIn;

  logic        done, ok, sticky;
  logic [15:0] bcount, ecount, fidx;
  logic [31:0] fexp, fgot;

  logic        s_done, s_ok, s_sticky;
  logic [3:0]  s_bcount, s_ecount;
  logic [15:0] s_fidx;
  logic [31:0] s_fexp, s_fgot;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_pattern_checker #(.BURST_LEN(256), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .Clear(Clear), .DataIn(DataIn), .DataInValid(DataInValid),
    .BurstDone(done), .BurstOk(ok), .ErrSticky(sticky), .BurstCount(bcount), .ErrCount(ecount),
    .FirstErrExp(fexp), .FirstErrGot(fgot), .FirstErrIdx(fidx)
  );

  stream_pattern_checker #(.BURST_LEN(256), .CNT_W(4)) dut_sat (
    .clk(clk), .rstn(rstn), .Clear(Clear), .DataIn(DataIn), .DataInValid(DataInValid),
    .BurstDone(s_done), .BurstOk(s_ok), .ErrSticky(s_sticky), .BurstCount(s_bcount), .ErrCount(s_ecount),
    .FirstErrExp(s_fexp), .FirstErrGot(s_fgot), .FirstErrIdx(s_fidx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; Clear = 1'b0; DataInValid = 1'b0; DataIn = 32'd0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  // Drives n words; optional corrupted word, optional skipped byte, optional Clear on the bad word.
  task automatic run_words(input int n, input logic [7:0] seed, input int bad_idx,
                           input logic [31:0] bad_val, input int drop_at, input logic clr_bad,
                           input logic [31:0] exp_cnt_after_bad);
    int dones = 0;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(int'(seed) + i + ((drop_at >= 0 && i >= drop_at) ? 1 : 0));
      DataIn      = (i == bad_idx) ? bad_val : {4{b}};
      DataInValid = 1'b1;
      Clear       = (i == bad_idx) && clr_bad;
      tick();
      Clear = 1'b0;
      if (done) dones++;
      if (i == bad_idx || i == drop_at) begin
        check("sticky_after_bad", 32'(sticky), 32'(!clr_bad));
        check("errcnt_after_bad", 32'(ecount), exp_cnt_after_bad);
      end
    end
    check("no_done_mid_burst", 32'(dones), 32'd0);
  endtask

  task automatic end_burst(input string name);
    DataInValid = 1'b0;
    tick();
    $display("burst %s: done=%0d ok=%0d bcount=%0d ecount=%0d idx=0x%0h", name, done, ok, bcount, ecount, fidx);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_done", 32'(done), 32'd0);
    check("rst_ok", 32'(ok), 32'd0);
    check("rst_sticky", 32'(sticky), 32'd0);
    check("rst_bcount", 32'(bcount), 32'd0);
    check("rst_ecount", 32'(ecount), 32'd0);
    check("rst_fexp", fexp, 32'd0);
    check("rst_fgot", fgot, 32'd0);
    check("rst_fidx", 32'(fidx), 32'd0);

    // Clean 256-word burst 0x01..0xFF,0x00
    run_words(256, 8'h01, -1, 32'd0, -1, 1'b0, 32'd0);
    end_burst("clean");
    check("clean_done", 32'(done), 32'd1);
    check("clean_ok", 32'(ok), 32'd1);
    check("clean_bcount", 32'(bcount), 32'd1);
    check("clean_ecount", 32'(ecount), 32'd0);
    check("clean_sticky", 32'(sticky), 32'd0);
    tick();
    check("clean_done_pulse", 32'(done), 32'd0);
    check("clean_ok_hold", 32'(ok), 32'd1);

    // Corrupt word 10
    do_reset();
    run_words(256, 8'h01, 10, 32'h0B0B0B0A, -1, 1'b0, 32'd1);
    check("corrupt_fidx", 32'(fidx), 32'd10);
    check("corrupt_fexp", fexp, 32'h0B0B0B0B);
    check("corrupt_fgot", fgot, 32'h0B0B0B0A);
    end_burst("corrupt");
    check("corrupt_done", 32'(done), 32'd1);
    check("corrupt_ok", 32'(ok), 32'd0);
    check("corrupt_fidx_frozen", 32'(fidx), 32'd10);

    // Short burst: length error
    do_reset();
    run_words(100, 8'h01, -1, 32'd0, -1, 1'b0, 32'd0);
    check("short_ecount_pre", 32'(ecount), 32'd0);
    end_burst("short");
    check("short_done", 32'(done), 32'd1);
    check("short_ok", 32'(ok), 32'd0);
    check("short_ecount", 32'(ecount), 32'd1);
    check("short_fexp", fexp, 32'd256);
    check("short_fgot", fgot, 32'd100);
    check("short_fidx", 32'(fidx), 32'hFFFF);
    check("short_sticky", 32'(sticky), 32'd1);

    // Dropped byte 0x06: one sequence error plus one length error
    do_reset();
    run_words(255, 8'h00, -1, 32'd0, 6, 1'b0, 32'd1);
    check("drop_no_avalanche", 32'(ecount), 32'd1);
    end_burst("dropped");
    check("drop_ecount", 32'(ecount), 32'd2);
    check("drop_fidx", 32'(fidx), 32'd6);
    check("drop_fexp", fexp, 32'h06060606);
    check("drop_fgot", fgot, 32'h07070707);
    check("drop_ok", 32'(ok), 32'd0);

    // Reset mid-burst, then a clean burst
    do_reset();
    run_words(50, 8'h01, -1, 32'd0, -1, 1'b0, 32'd0);
    DataIn = {4{8'd51}}; DataInValid = 1'b1; rstn = 1'b0;
    tick();
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcount", 32'(bcount), 32'd0);
    rstn = 1'b1; DataInValid = 1'b0;
    tick();
    check("midrst_no_done", 32'(done), 32'd0);
    run_words(256, 8'h01, -1, 32'd0, -1, 1'b0, 32'd0);
    end_burst("after_reset");
    check("midrst_clean_done", 32'(done), 32'd1);
    check("midrst_clean_bcount", 32'(bcount), 32'd1);
    check("midrst_clean_ok", 32'(ok), 32'd1);

    // Clear in the same cycle as a bad word (non-replicated word keeps sequence intact)
    do_reset();
    run_words(256, 8'h01, 10, 32'h0A0B0B0B, -1, 1'b1, 32'd0);
    check("clear_fidx", 32'(fidx), 32'd0);
    end_burst("clear");
    check("clear_done", 32'(done), 32'd1);
    check("clear_ok", 32'(ok), 32'd0);
    check("clear_ecount", 32'(ecount), 32'd0);
    check("clear_sticky", 32'(sticky), 32'd0);
    check("clear_bcount", 32'(bcount), 32'd1);

    // Saturation: 20 two-word bursts, each a length error
    do_reset();
    for (int k = 0; k < 20; k++) begin
      run_words(2, 8'h10, -1, 32'd0, -1, 1'b0, 32'd0);
      end_burst("sat");
    end
    check("sat_ecount4", 32'(s_ecount), 32'hF);
    check("sat_bcount4", 32'(s_bcount), 32'hF);
    check("sat_fgot4", s_fgot, 32'd2);
    check("sat_ecount16", 32'(ecount), 32'd20);
    check("sat_bcount16", 32'(bcount), 32'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
